// File: rtl/arm_bp_pkg.sv
// Shared types for the ARM branch predictor: 2-bit counter encoding, BTB entry layout
// and the update operations the E stage can request on the table.
package arm_bp_pkg;

   localparam int BP_PC_W  = 32;
   localparam int BP_TAG_W = BP_PC_W - 3;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   typedef enum logic [1:0] {
      BP_UPD_NONE  = 2'b00,
      BP_UPD_TRAIN = 2'b01,
      BP_UPD_ALLOC = 2'b10,
      BP_UPD_INVAL = 2'b11
   } bp_upd_t;

   // Tag and target are held at full width and zero-extended, so narrower
   // configurations still compare every stored bit.
   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_PC_W-1:0]  target;
      bp_ctr_t             ctr;
   } bp_entry_t;

   function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
      bp_ctr_t nxt;
      nxt = ctr;
      if (taken && (ctr != ST)) begin
         nxt = bp_ctr_t'(ctr + 2'd1);
      end else if (!taken && (ctr != SNT)) begin
         nxt = bp_ctr_t'(ctr - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/arm_bp_table.sv
// Direct-mapped BTB storage: asynchronous lookup port for F, read-modify-write port for E.
module arm_bp_table
   import arm_bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    f_idx_i,
   output bp_entry_t           f_entry_o,
   input  bp_upd_t             e_op_i,
   input  logic [IDX_W-1:0]    e_idx_i,
   input  logic [BP_TAG_W-1:0] e_tag_i,
   input  logic                e_taken_i,
   input  logic [BP_PC_W-1:0]  e_target_i
);

   bp_entry_t tbl_q [ENTRIES];
   bp_entry_t entry_d;

   // The F port reads the registered array, so a same-cycle update is not visible until the next cycle.
   assign f_entry_o = tbl_q[f_idx_i];

   always_comb begin
      entry_d = tbl_q[e_idx_i];
      unique case (e_op_i)
         BP_UPD_TRAIN: begin
            entry_d.ctr = bp_ctr_next(tbl_q[e_idx_i].ctr, e_taken_i);
            if (e_taken_i) begin
               entry_d.target = e_target_i;
            end
         end
         BP_UPD_ALLOC: begin
            entry_d.valid  = 1'b1;
            entry_d.tag    = e_tag_i;
            entry_d.target = e_target_i;
            entry_d.ctr    = WT;
         end
         BP_UPD_INVAL: begin
            entry_d.valid = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_q[i].valid <= 1'b0;
            tbl_q[i].ctr   <= WNT;
         end
      end else if (e_op_i != BP_UPD_NONE) begin
         tbl_q[e_idx_i] <= entry_d;
      end
   end

endmodule

// File: rtl/arm_branch_predictor.sv
// BTB-based dynamic branch predictor: predicts in F, carries the prediction through D/E,
// resolves in E, trains the table and keeps saturating performance counters.
module arm_branch_predictor
   import arm_bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PC_W-1:0]  PCF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             FlushE,
   input  logic             BranchE,
   input  logic             BranchTakenE,
   input  logic [PC_W-1:0]  ALUResultE,
   output logic             PredTakenF,
   output logic [PC_W-1:0]  PredTargetF,
   output logic             MispredictE,
   output logic [PC_W-1:0]  RedirectPCE,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] MispredictCount
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
      logic            hit;
   } pred_reg_t;

   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   logic [IDX_W-1:0] idx_e;
   logic [TAG_W-1:0] tag_e;
   bp_entry_t        ent_f;
   logic             hit_f;
   bp_upd_t          upd_op;

   pred_reg_t pipe_f;
   pred_reg_t pipe_d_d, pipe_d_q;
   pred_reg_t pipe_e_d, pipe_e_q;

   logic [CNT_W-1:0] bcnt_d, bcnt_q;
   logic [CNT_W-1:0] mcnt_d, mcnt_q;

   assign idx_f = PCF[IDX_W+1:2];
   assign tag_f = PCF[PC_W-1:IDX_W+2];
   assign idx_e = pipe_e_q.pc[IDX_W+1:2];
   assign tag_e = pipe_e_q.pc[PC_W-1:IDX_W+2];

   arm_bp_table #(
      .ENTRIES (ENTRIES)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .f_idx_i    (idx_f),
      .f_entry_o  (ent_f),
      .e_op_i     (upd_op),
      .e_idx_i    (idx_e),
      .e_tag_i    (BP_TAG_W'(tag_e)),
      .e_taken_i  (BranchTakenE),
      .e_target_i (BP_PC_W'(ALUResultE))
   );

   assign hit_f       = ent_f.valid && (ent_f.tag == BP_TAG_W'(tag_f));
   assign PredTakenF  = hit_f && ent_f.ctr[1];
   assign PredTargetF = PredTakenF ? ent_f.target[PC_W-1:0] : (PCF + PC_W'(4));

   always_comb begin
      pipe_f.pc          = PCF;
      pipe_f.pred_taken  = PredTakenF;
      pipe_f.pred_target = PredTargetF;
      pipe_f.hit         = hit_f;
   end

   always_comb begin
      pipe_d_d = pipe_d_q;
      if (FlushD) begin
         pipe_d_d = '0;
      end else if (!StallD) begin
         pipe_d_d = pipe_f;
      end
      pipe_e_d = FlushE ? '0 : pipe_d_q;
   end

   // A predicted-taken non-branch is a stale or aliased entry and must be undone.
   always_comb begin
      MispredictE = 1'b0;
      if (BranchE) begin
         MispredictE = (pipe_e_q.pred_taken != BranchTakenE) ||
                       (pipe_e_q.pred_taken && BranchTakenE &&
                        (pipe_e_q.pred_target != ALUResultE));
      end else begin
         MispredictE = pipe_e_q.pred_taken;
      end
   end

   assign RedirectPCE = (BranchE && BranchTakenE) ? ALUResultE : (pipe_e_q.pc + PC_W'(4));

   always_comb begin
      upd_op = BP_UPD_NONE;
      if (BranchE) begin
         if (pipe_e_q.hit) begin
            upd_op = BP_UPD_TRAIN;
         end else if (BranchTakenE) begin
            upd_op = BP_UPD_ALLOC;
         end
      end else if (pipe_e_q.pred_taken) begin
         upd_op = BP_UPD_INVAL;
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      mcnt_d = mcnt_q;
      if (BranchE && (bcnt_q != '1)) begin
         bcnt_d = bcnt_q + CNT_W'(1);
      end
      if (MispredictE && (mcnt_q != '1)) begin
         mcnt_d = mcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_d_q <= '0;
         pipe_e_q <= '0;
         bcnt_q   <= '0;
         mcnt_q   <= '0;
      end else begin
         pipe_d_q <= pipe_d_d;
         pipe_e_q <= pipe_e_d;
         bcnt_q   <= bcnt_d;
         mcnt_q   <= mcnt_d;
      end
   end

   assign BranchCount     = bcnt_q;
   assign MispredictCount = mcnt_q;

endmodule
